// File: rtl/jt900h_dump.sv
// jt900h_dump: streams a framed, checksummed snapshot of the CPU register file
module jt900h_dump #(
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter logic [7:0] LAST_ADDR = 8'd81
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       freeze,
  output logic       busy,
  output logic       done,
  output logic [7:0] dmp_addr,
  input  logic [7:0] dmp_dout,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);
  typedef enum logic [2:0] {IDLE, HDR, RD, SEND, CKS, FIN} state_t;
  state_t state, next;
  logic [7:0] sum, data;
  logic xfer;
  assign xfer = out_valid & out_ready;
  // next state and stream/handshake outputs, all decoded from the state
  always_comb begin
    next = state;
    out_valid = 1'b0;
    out_data = data;
    busy = state != IDLE;
    freeze = state != IDLE;
    done = state == FIN;
    case (state)
      IDLE: next = start ? HDR : IDLE;
      HDR: begin
        out_valid = 1'b1;
        out_data = HEADER;
        next = xfer ? RD : HDR;
      end
      RD: next = SEND;
      SEND: begin
        out_valid = 1'b1;
        next = xfer ? (dmp_addr == LAST_ADDR ? CKS : RD) : SEND;
      end
      CKS: begin
        out_valid = 1'b1;
        out_data = -sum;
        next = xfer ? FIN : CKS;
      end
      default: next = IDLE;
    endcase
  end
  // state, dump address, running checksum and captured dump byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      dmp_addr <= 8'd0;
      sum <= 8'd0;
      data <= 8'd0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        dmp_addr <= 8'd0;
        sum <= 8'd0;
      end
      if (xfer) sum <= sum + out_data;
      if (state == RD) data <= dmp_dout;
      if (state == SEND && xfer && dmp_addr != LAST_ADDR) dmp_addr <= dmp_addr + 8'd1;
    end
  end
endmodule

// File: tb/tb_jt900h_dump.sv
// tb_jt900h_dump: random and directed frame checks against a byte-stream model
module tb_jt900h_dump;
  localparam int LAST = 81;
  localparam logic [7:0] HB = 8'hA5;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic freeze, busy, done, out_valid;
  logic [7:0] dmp_addr, dmp_dout, out_data;
  logic start2 = 1'b0, freeze2, busy2, done2, out_valid2;
  logic [7:0] dmp_addr2, out_data2;
  logic [7:0] mem [0:LAST];
  int vectors = 0, errs = 0;
  int nbytes = 0, busy_cyc = 0, done_cnt = 0;
  logic [7:0] last_byte = 8'd0;
  typedef struct {logic [7:0] d; int a;} ent_t;
  ent_t q[$];
  bit mbusy = 0, mdone = 0, prst = 0, pstall = 0;
  logic [7:0] pd = 8'd0, pa = 8'd0;
  logic [7:0] q2[$];
  int busy2_cyc = 0, done2_cnt = 0;

  always #5 clk = ~clk;

  assign dmp_dout = (int'(dmp_addr) <= LAST) ? mem[dmp_addr] : 8'd0;

  jt900h_dump dut (
    .clk(clk), .rst(rst), .start(start), .freeze(freeze), .busy(busy), .done(done),
    .dmp_addr(dmp_addr), .dmp_dout(dmp_dout), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  jt900h_dump #(.HEADER(8'hA5), .LAST_ADDR(8'd3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .freeze(freeze2), .busy(busy2), .done(done2),
    .dmp_addr(dmp_addr2), .dmp_dout(8'h00), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(1'b1)
  );

  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // reference: a frame is HEADER, mem[0..LAST], then the byte that zeroes the total
  task automatic load_frame();
    int s;
    q.delete();
    q.push_back('{HB, -1});
    s = int'(HB);
    for (int i = 0; i <= LAST; i++) begin
      q.push_back('{mem[i], i});
      s += int'(mem[i]);
    end
    q.push_back('{8'((256 - s % 256) % 256), -1});
  endtask

  // per-cycle compare of the DUT against the model
  always @(negedge clk) begin
    bit xf, mdone_n;
    ent_t e;
    chk("busy", busy, mbusy);
    chk("freeze", freeze, mbusy);
    chk("done", done, mdone);
    if (!mbusy) chk("idle_valid", out_valid, 0);
    if (!prst) chk("reset_state", {out_valid, busy, freeze, done, dmp_addr, out_data}, 0);
    if (pstall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, pd);
      chk("stall_addr", dmp_addr, pa);
    end
    xf = out_valid && out_ready;
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (xf) begin
      if (q.size() == 0) chk("extra_byte", 1, 0);
      else begin
        e = q.pop_front();
        chk("byte", out_data, e.d);
        if (e.a >= 0) chk("byte_addr", dmp_addr, e.a);
        nbytes++;
        last_byte = out_data;
      end
    end
    pstall = rst && out_valid && !out_ready;
    pd = out_data;
    pa = dmp_addr;
    prst = rst;
    if (!rst) begin
      mbusy = 0;
      mdone = 0;
      q.delete();
    end else begin
      mdone_n = xf && mbusy && q.size() == 0;
      if (mdone) mbusy = 0;
      else if (!mbusy && start) begin
        mbusy = 1;
        load_frame();
      end
      mdone = mdone_n;
    end
  end

  // recorder for the short-frame instance
  always @(negedge clk) begin
    if (out_valid2) q2.push_back(out_data2);
    if (busy2) busy2_cyc++;
    if (done2) done2_cnt++;
  end

  task automatic run_frame(input int mode, input int repulse_at);
    int c, d0;
    d0 = done_cnt;
    nbytes = 0;
    busy_cyc = 0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (done_cnt == d0 && c < 3000) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
      start = (nbytes == repulse_at);
      @(posedge clk); #1;
      c++;
    end
    if (c >= 3000) chk("frame_timeout", 0, 1);
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("one_done", done_cnt, d0 + 1);
    chk("frame_len", nbytes, LAST + 3);
  endtask

  initial begin
    int c, d0;
    for (int i = 0; i <= LAST; i++) mem[i] = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mem[77] = 8'h01;
    mem[80] = 8'hF8;
    run_frame(0, -1);
    chk("cks_reset_regs", last_byte, 8'h62);
    chk("cycles_hdr_fin", busy_cyc, 167);
    run_frame(1, -1);
    chk("cks_stalled", last_byte, 8'h62);
    mem[0] = 8'h78; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
    run_frame(0, -1);
    chk("cks_xwa0", last_byte, 8'h4E);
    run_frame(0, 10);
    chk("repulse_cycles", busy_cyc, 167);
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (dmp_addr != 8'd40 && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reach_addr40", dmp_addr, 40);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    run_frame(0, -1);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i <= LAST; i++) mem[i] = 8'($urandom);
      run_frame(2, (f == 1) ? 30 : -1);
    end
    q2.delete();
    busy2_cyc = 0;
    d0 = done2_cnt;
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    c = 0;
    while (done2_cnt == d0 && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("short_done", done2_cnt, d0 + 1);
    chk("short_cycles", busy2_cyc, 11);
    chk("short_len", q2.size(), 6);
    if (q2.size() == 6) begin
      chk("short_b0", q2[0], 8'hA5);
      for (int i = 1; i < 5; i++) chk("short_data", q2[i], 8'h00);
      chk("short_cks", q2[5], 8'h5B);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
